// File: rtl/mac_relu_unit.sv
// ---------------------------------------------------------------------------
// mac_relu_unit
//   Two-stage multiply-accumulate with a combinational ReLU tap on the
//   accumulator. Stage 1 registers the reduced product a*b and a valid bit.
//   Stage 2 adds that product into acc whenever the valid bit is set.
//   There is no FSM; the only clear mechanism is rst.
//
//   Optional feature macro: MAC_SATURATE_EN
//     undefined : the product is truncated to WIDTH bits, the accumulator
//                 wraps modulo 2^WIDTH, and sat is tied to 0.
//     defined   : the product and every addition clamp to the signed WIDTH
//                 range. sat is sticky on any clamp until rst.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (clears all state)
//   enable   in   sample a/b this cycle
//   a, b     in   WIDTH-bit signed operands (pixel, weight)
//   acc      out  registered signed accumulator
//   relu_acc out  acc when non-negative, else 0 (combinational)
//   busy     out  stage-1 valid: a sampled product not yet in acc
//   sat      out  sticky saturation flag
// ---------------------------------------------------------------------------
module mac_relu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] relu_acc,
   output logic             busy,
   output logic             sat
);

   logic [WIDTH-1:0] prod_q, prod_d;
   logic             vld_q,  vld_d;
   logic [WIDTH-1:0] acc_q,  acc_d;
   logic [WIDTH-1:0] prod_red;

`ifdef MAC_SATURATE_EN
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] full_prod;
   logic                      prod_ovf;
   logic [WIDTH:0]            sum_ext;
   logic                      sum_ovf;
   logic                      clamp_q, clamp_d;
   logic                      sat_q,   sat_d;

   // Operands are sign-extended to 2*WIDTH by the assignment context.
   assign full_prod = $signed(a) * $signed(b);

   // The product fits in WIDTH bits only when its top WIDTH+1 bits all
   // match the sign.
   assign prod_ovf = !((&full_prod[2*WIDTH-1:WIDTH-1]) ||
                       (~|full_prod[2*WIDTH-1:WIDTH-1]));

   always_comb begin
      prod_red = full_prod[WIDTH-1:0];
      if (prod_ovf) prod_red = full_prod[2*WIDTH-1] ? SMIN : SMAX;
   end

   // One guard bit: overflow shows up as the two top bits differing.
   assign sum_ext = {acc_q[WIDTH-1], acc_q} + {prod_q[WIDTH-1], prod_q};
   assign sum_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];

   always_comb begin
      acc_d   = acc_q;
      sat_d   = sat_q;
      // A clamp is reported when the clamped product lands in acc, so that
      // sat and acc change together.
      clamp_d = enable & prod_ovf;
      if (vld_q) begin
         acc_d = sum_ext[WIDTH-1:0];
         if (sum_ovf) acc_d = sum_ext[WIDTH] ? SMIN : SMAX;
         sat_d = sat_q | sum_ovf | clamp_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clamp_q <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         clamp_q <= clamp_d;
         sat_q   <= sat_d;
      end
   end

   assign sat = sat_q;
`else
   // The low WIDTH bits of a two's complement product do not depend on the
   // operand signs, so a WIDTH-wide multiply gives the truncated
   // full-precision product directly.
   assign prod_red = a * b;

   always_comb begin
      acc_d = acc_q;
      if (vld_q) acc_d = acc_q + prod_q;
   end

   assign sat = 1'b0;
`endif

   // Stage 1. The product is zeroed when idle, so undriven operands never
   // reach a flop.
   always_comb begin
      vld_d  = enable;
      prod_d = enable ? prod_red : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         vld_q  <= 1'b0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         vld_q  <= vld_d;
         acc_q  <= acc_d;
      end
   end

   assign acc      = acc_q;
   assign relu_acc = acc_q[WIDTH-1] ? '0 : acc_q;
   assign busy     = vld_q;

endmodule

// File: tb/tb_mac_relu_unit.sv
module tb_mac_relu_unit;

   logic        clk, rst, enable;
   logic [31:0] a, b;
   logic [31:0] acc, relu_acc;
   logic        busy, sat;

   int n_assert = 0;
   int n_fail   = 0;

   mac_relu_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b),
      .acc(acc), .relu_acc(relu_acc), .busy(busy), .sat(sat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a queue of products sampled but not yet accumulated,
   // plus the accumulator value as a plain integer.
   typedef struct { longint p; bit c; } ent_t;
   ent_t   pend[$];
   longint m_acc = 0;
   bit     m_sat = 0;

   localparam longint SMAXV =  64'sd2147483647;
   localparam longint SMINV = -64'sd2147483648;

   function automatic longint wrap32(input longint x);
      int t;
      t = int'(x);
      return longint'(t);
   endfunction

   task automatic model_step(input bit r, input bit en, input logic [31:0] ia, input logic [31:0] ib);
      ent_t   e;
      longint s, pf;
      if (r) begin
         pend.delete();
         m_acc = 0;
         m_sat = 0;
         return;
      end
      if (pend.size() != 0) begin
         e = pend.pop_front();
         s = m_acc + e.p;
`ifdef MAC_SATURATE_EN
         if (s > SMAXV) begin s = SMAXV; m_sat = 1; end
         if (s < SMINV) begin s = SMINV; m_sat = 1; end
         if (e.c) m_sat = 1;
`else
         s = wrap32(s);
`endif
         m_acc = s;
      end
      if (en) begin
         pf  = longint'($signed(ia)) * longint'($signed(ib));
         e.c = 0;
`ifdef MAC_SATURATE_EN
         if (pf > SMAXV) begin pf = SMAXV; e.c = 1; end
         if (pf < SMINV) begin pf = SMINV; e.c = 1; end
`else
         pf = wrap32(pf);
`endif
         e.p = pf;
         pend.push_back(e);
      end
   endtask

   // Inputs are driven at the falling edge; outputs are checked there too.
   task automatic tick(input bit r, input bit en, input logic [31:0] ia, input logic [31:0] ib);
      rst = r; enable = en; a = ia; b = ib;
      @(posedge clk);
      model_step(r, en, ia, ib);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, $urandom, $urandom);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] ea;
      ea = m_acc[31:0];
      chk({tag, ".acc"},  acc, ea);
      chk({tag, ".relu"}, relu_acc, (m_acc < 0) ? 32'd0 : ea);
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, pend.size() != 0});
      chk({tag, ".sat"},  {31'd0, sat},  {31'd0, m_sat});
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; a = '0; b = '0;
      @(negedge clk);

      // Reset with enable high: enable must be ignored.
      tick(1, 1, 32'd5, 32'd7);
      chk("reset.acc",  acc, 32'd0);
      chk("reset.relu", relu_acc, 32'd0);
      chk("reset.busy", {31'd0, busy}, 32'd0);
      chk("reset.sat",  {31'd0, sat}, 32'd0);
      tick(0, 0, 0, 0);
      chk("reset.hold", acc, 32'd0);

      // 3x3 window, positive result.
      tick(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) tick(0, 1, 32'(10 * (i / 3 + 1)), 32'(i / 3 - 1));
      idle(2);
      chk("win_pos.acc",  acc, 32'd60);
      chk("win_pos.relu", relu_acc, 32'd60);
      check_model("win_pos");

      // Same window with pixel rows swapped.
      tick(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) tick(0, 1, 32'(10 * (3 - i / 3)), 32'(i / 3 - 1));
      idle(2);
      chk("win_neg.acc",  acc, 32'hFFFF_FFC4);
      chk("win_neg.relu", relu_acc, 32'd0);
      check_model("win_neg");

      // Gapped enables.
      tick(1, 0, 0, 0);
      tick(0, 1, 32'd3, 32'd4);
      chk("gap.busy1", {31'd0, busy}, 32'd1);
      chk("gap.acc_pre", acc, 32'd0);
      idle(1);
      chk("gap.acc12", acc, 32'd12);
      chk("gap.busy0", {31'd0, busy}, 32'd0);
      idle(1);
      chk("gap.hold", acc, 32'd12);
      tick(0, 1, 32'd5, -32'sd2);
      chk("gap.busy2", {31'd0, busy}, 32'd1);
      chk("gap.acc_mid", acc, 32'd12);
      idle(1);
      chk("gap.acc2", acc, 32'd2);
      chk("gap.busy3", {31'd0, busy}, 32'd0);
      check_model("gap");

      // Reset mid-window discards in-flight work.
      tick(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick(0, 1, 32'd7, 32'd9);
      tick(1, 0, 0, 0);
      chk("midrst.acc",  acc, 32'd0);
      chk("midrst.busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 9; i++) tick(0, 1, 32'd1, 32'd1);
      idle(2);
      chk("midrst.acc9", acc, 32'd9);
      check_model("midrst");

      // Product overflow.
      tick(1, 0, 0, 0);
      tick(0, 1, 32'h4000_0000, 32'd4);
      idle(2);
`ifdef MAC_SATURATE_EN
      chk("povf.acc", acc, 32'h7FFF_FFFF);
      chk("povf.sat", {31'd0, sat}, 32'd1);
`else
      chk("povf.acc", acc, 32'd0);
      chk("povf.sat", {31'd0, sat}, 32'd0);
`endif
      check_model("povf");

      // Accumulator overflow from the positive limit.
      tick(1, 0, 0, 0);
      tick(0, 1, 32'h7FFF_FFFF, 32'd1);
      idle(2);
      chk("aovf.pre", acc, 32'h7FFF_FFFF);
      tick(0, 1, 32'd1, 32'd1);
      idle(2);
`ifdef MAC_SATURATE_EN
      chk("aovf.acc", acc, 32'h7FFF_FFFF);
      chk("aovf.sat", {31'd0, sat}, 32'd1);
`else
      chk("aovf.acc",  acc, 32'h8000_0000);
      chk("aovf.relu", relu_acc, 32'd0);
`endif
      check_model("aovf");

      // Random traffic against the model, with occasional resets.
      tick(1, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         bit          r, en;
         logic [31:0] ra, rb;
         r  = ($urandom_range(0, 60) == 0);
         en = ($urandom_range(0, 3) != 0);
         ra = ($urandom_range(0, 4) == 0) ? $urandom : 32'($signed($urandom_range(0, 400)) - 200);
         rb = ($urandom_range(0, 4) == 0) ? $urandom : 32'($signed($urandom_range(0, 400)) - 200);
         tick(r, en, ra, rb);
         check_model("rand");
      end
      idle(2);
      check_model("drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
